char_buffer_writer: RTL and testbench

Write-side controller for the 80x24 character buffer: accepts one byte per handshake from the host/UART side, interprets printable characters and the control codes CR, LF and BS, and issues writes into the dual-port char buffer. It owns the cursor and the circular-buffer scroll pointer, which it publishes as `buffer_first_char`. It clears the screen after reset and clears the new bottom line on scroll. Its buffer outputs connect directly to the display char generator's `buffer_*` inputs.

---
 rtl/char_buffer_writer_pkg.sv | 23 ++
 rtl/char_buffer_writer_addr_wrap_add.sv | 27 ++
 rtl/char_buffer_writer.sv | 213 +++++++++++++++++++++
 tb/tb_char_buffer_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/char_buffer_writer_pkg.sv
// Shared VT52 terminal definitions: screen geometry, control codes and the
// legacy state encodings of the character buffer writer.
package vt52_defs;

  localparam int unsigned ROWS          = 24;
  localparam int unsigned COLS          = 80;
  localparam int unsigned PAST_LAST_ROW = ROWS * COLS;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_TILDE = 8'h7E;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_SPACE) && (c <= CHAR_TILDE);
  endfunction

endpackage

// File: rtl/char_buffer_writer_addr_wrap_add.sv
// Buffer address adder with wrap at the buffer size (compare-and-subtract).
// Operands must already be below PAST_LAST_ROW; b may equal PAST_LAST_ROW.
module addr_wrap_add #(
  parameter int unsigned ADDR_BITS     = 11,
  parameter int unsigned PAST_LAST_ROW = vt52_defs::PAST_LAST_ROW
) (
  input  logic [ADDR_BITS-1:0] a,
  input  logic [ADDR_BITS-1:0] b,
  output logic [ADDR_BITS-1:0] sum
);

  localparam logic [ADDR_BITS:0] LIMIT = (ADDR_BITS+1)'(PAST_LAST_ROW);

  logic [ADDR_BITS:0] raw;
  logic [ADDR_BITS:0] wrapped;

  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    wrapped = raw - LIMIT;
    if (raw >= LIMIT) begin
      sum = wrapped[ADDR_BITS-1:0];
    end else begin
      sum = raw[ADDR_BITS-1:0];
    end
  end

endmodule

// File: rtl/char_buffer_writer.sv
// Write-side controller for the 80x24 character buffer: decodes host bytes,
// owns the cursor and scroll pointer, and clears the screen / scrolled line.
module char_buffer_writer #(
  parameter int unsigned ROWS          = vt52_defs::ROWS,
  parameter int unsigned COLS          = vt52_defs::COLS,
  parameter int unsigned ROW_BITS      = 5,
  parameter int unsigned COL_BITS      = 7,
  parameter int unsigned ADDR_BITS     = 11,
  parameter int unsigned PAST_LAST_ROW = ROWS * COLS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [7:0]           data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col
);

  import vt52_defs::CHAR_SPACE;
  import vt52_defs::CHAR_CR;
  import vt52_defs::CHAR_LF;
  import vt52_defs::CHAR_BS;
  import vt52_defs::ST_INIT;
  import vt52_defs::ST_IDLE;
  import vt52_defs::ST_SCROLL;
  import vt52_defs::is_printable;

  localparam logic [ROW_BITS-1:0]  LAST_ROW     = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]  LAST_COL     = COL_BITS'(COLS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR    = ADDR_BITS'(PAST_LAST_ROW - 1);
  localparam logic [ADDR_BITS-1:0] BUF_SIZE     = ADDR_BITS'(PAST_LAST_ROW);
  localparam logic [ADDR_BITS-1:0] LINE_LEN     = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_IN_LINE = ADDR_BITS'(COLS - 1);

  logic [1:0]           state_q, state_d;
  logic                 done_q, done_d;
  logic [ADDR_BITS-1:0] first_char_q, first_char_d;
  logic [ADDR_BITS-1:0] cursor_addr_q, cursor_addr_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ADDR_BITS-1:0] clear_addr_q, clear_addr_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]           din_q, din_d;
  logic                 wen_q, wen_d;
  logic                 fc_wen_q, fc_wen_d;

  logic [ADDR_BITS-1:0] cur_step;
  logic [ADDR_BITS-1:0] cur_next;
  logic [ADDR_BITS-1:0] fc_next;

  // Backward moves add (BUF_SIZE - n) so one wrapping adder serves every move.
  always_comb begin
    cur_step = ADDR_BITS'(1);
    unique case (data_in)
      CHAR_CR: cur_step = BUF_SIZE - ADDR_BITS'(col_q);
      CHAR_BS: cur_step = BUF_SIZE - ADDR_BITS'(1);
      CHAR_LF: cur_step = LINE_LEN;
      default: cur_step = ADDR_BITS'(1);
    endcase
  end

  addr_wrap_add #(
    .ADDR_BITS     (ADDR_BITS),
    .PAST_LAST_ROW (PAST_LAST_ROW)
  ) u_cursor_add (
    .a   (cursor_addr_q),
    .b   (cur_step),
    .sum (cur_next)
  );

  addr_wrap_add #(
    .ADDR_BITS     (ADDR_BITS),
    .PAST_LAST_ROW (PAST_LAST_ROW)
  ) u_first_char_add (
    .a   (first_char_q),
    .b   (LINE_LEN),
    .sum (fc_next)
  );

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    first_char_d  = first_char_q;
    cursor_addr_d = cursor_addr_q;
    row_d         = row_q;
    col_d         = col_q;
    clear_addr_d  = clear_addr_q;
    waddr_d       = waddr_q;
    din_d         = din_q;
    wen_d         = 1'b0;
    fc_wen_d      = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // done_q adds the idle cycle between the last clear write and ready.
        if (done_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          wen_d        = 1'b1;
          waddr_d      = clear_addr_q;
          din_d        = CHAR_SPACE;
          clear_addr_d = clear_addr_q + 1'b1;
          if (clear_addr_q == LAST_ADDR) begin
            done_d       = 1'b1;
            fc_wen_d     = 1'b1;
            first_char_d = '0;
          end
        end
      end

      ST_IDLE: begin
        if (valid_in) begin
          if (is_printable(data_in)) begin
            wen_d   = 1'b1;
            waddr_d = cursor_addr_q;
            din_d   = data_in;
            if (col_q < LAST_COL) begin
              col_d         = col_q + 1'b1;
              cursor_addr_d = cur_next;
            end
          end else if (data_in == CHAR_CR) begin
            col_d         = '0;
            cursor_addr_d = cur_next;
          end else if (data_in == CHAR_BS) begin
            if (col_q != '0) begin
              col_d         = col_q - 1'b1;
              cursor_addr_d = cur_next;
            end
          end else if (data_in == CHAR_LF) begin
            if (row_q != LAST_ROW) begin
              row_d         = row_q + 1'b1;
              cursor_addr_d = cur_next;
            end else begin
              state_d      = ST_SCROLL;
              clear_addr_d = first_char_q;
              done_d       = 1'b0;
            end
          end
        end
      end

      ST_SCROLL: begin
        if (done_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          wen_d        = 1'b1;
          waddr_d      = clear_addr_q;
          din_d        = CHAR_SPACE;
          clear_addr_d = clear_addr_q + 1'b1;
          // The cleared line becomes the new bottom row, so the cursor lands in it.
          if (clear_addr_q == first_char_q + LAST_IN_LINE) begin
            done_d        = 1'b1;
            fc_wen_d      = 1'b1;
            first_char_d  = fc_next;
            cursor_addr_d = first_char_q + ADDR_BITS'(col_q);
          end
        end
      end

      default: begin
        state_d      = ST_INIT;
        done_d       = 1'b0;
        clear_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= ST_INIT;
      done_q        <= 1'b0;
      first_char_q  <= '0;
      cursor_addr_q <= '0;
      row_q         <= '0;
      col_q         <= '0;
      clear_addr_q  <= '0;
      waddr_q       <= '0;
      din_q         <= '0;
      wen_q         <= 1'b0;
      fc_wen_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      first_char_q  <= first_char_d;
      cursor_addr_q <= cursor_addr_d;
      row_q         <= row_d;
      col_q         <= col_d;
      clear_addr_q  <= clear_addr_d;
      waddr_q       <= waddr_d;
      din_q         <= din_d;
      wen_q         <= wen_d;
      fc_wen_q      <= fc_wen_d;
    end
  end

  assign ready_out             = (state_q == ST_IDLE);
  assign buffer_waddr          = waddr_q;
  assign buffer_din            = din_q;
  assign buffer_wen            = wen_q;
  assign buffer_first_char     = first_char_q;
  assign buffer_first_char_wen = fc_wen_q;
  assign cursor_row            = row_q;
  assign cursor_col            = col_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed bench for char_buffer_writer: screen clear, printing, cursor
// control codes, scrolling, scroll-pointer wrap and reset during a scroll.
module tb_char_buffer_writer;

  logic        clk;
  logic        clr;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic [10:0] buffer_waddr;
  logic [7:0]  buffer_din;
  logic        buffer_wen;
  logic [10:0] buffer_first_char;
  logic        buffer_first_char_wen;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  int errors = 0;
  int checks = 0;

  char_buffer_writer dut (
    .clk                   (clk),
    .clr                   (clr),
    .data_in               (data_in),
    .valid_in              (valid_in),
    .ready_out             (ready_out),
    .buffer_waddr          (buffer_waddr),
    .buffer_din            (buffer_din),
    .buffer_wen            (buffer_wen),
    .buffer_first_char     (buffer_first_char),
    .buffer_first_char_wen (buffer_first_char_wen),
    .cursor_row            (cursor_row),
    .cursor_col            (cursor_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte, waits (bounded) for ready, and returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    data_in  = b;
    valid_in = 1'b1;
    while (!ready_out && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (!ready_out) begin
      errors++;
      $display("FAIL send_timeout: ready_out=%b after %0d cycles, required 1", ready_out, n);
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_out && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (!ready_out) begin
      errors++;
      $display("FAIL %s_ready_timeout: ready_out=%b, required 1", tag, ready_out);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    #3;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready_out); end
    checks++; if (buffer_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b want 0", buffer_wen); end
    checks++; if (buffer_first_char_wen !== 1'b0) begin errors++; $display("FAIL rst_fc_wen: got %b want 0", buffer_first_char_wen); end
    checks++; if (buffer_waddr !== 11'd0) begin errors++; $display("FAIL rst_waddr: got %0d want 0", buffer_waddr); end
    checks++; if (buffer_din !== 8'h00) begin errors++; $display("FAIL rst_din: got %h want 00", buffer_din); end
    checks++; if (buffer_first_char !== 11'd0) begin errors++; $display("FAIL rst_fc: got %0d want 0", buffer_first_char); end
    checks++; if (cursor_row !== 5'd0) begin errors++; $display("FAIL rst_row: got %0d want 0", cursor_row); end
    checks++; if (cursor_col !== 7'd0) begin errors++; $display("FAIL rst_col: got %0d want 0", cursor_col); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (buffer_wen !== 1'b0) begin errors++; $display("FAIL rst_hold_wen: got %b want 0", buffer_wen); end
    end
  endtask

  task automatic test_init_clear();
    clr = 1'b0;
    for (int i = 0; i < 1920; i++) begin
      step();
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(i) || buffer_din !== 8'h20 || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL init_write[%0d]: wen=%b addr=%0d din=%h ready=%b want wen=1 addr=%0d din=20 ready=0",
                 i, buffer_wen, buffer_waddr, buffer_din, ready_out, i);
      end
      checks++;
      if (buffer_first_char_wen !== (i == 1919)) begin
        errors++;
        $display("FAIL init_fc_wen[%0d]: got %b want %b", i, buffer_first_char_wen, (i == 1919));
      end
    end
    checks++; if (buffer_first_char !== 11'd0) begin errors++; $display("FAIL init_fc: got %0d want 0", buffer_first_char); end
    step();
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", ready_out); end
    checks++; if (buffer_wen !== 1'b0) begin errors++; $display("FAIL init_end_wen: got %b want 0", buffer_wen); end
  endtask

  task automatic test_printable();
    data_in = 8'h41; valid_in = 1'b1;
    step();
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd0 || buffer_din !== 8'h41) begin errors++; $display("FAIL print_A: wen=%b addr=%0d din=%h want 1/0/41", buffer_wen, buffer_waddr, buffer_din); end
    checks++; if (cursor_col !== 7'd1) begin errors++; $display("FAIL print_A_col: got %0d want 1", cursor_col); end
    data_in = 8'h42;
    step();
    valid_in = 1'b0;
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd1 || buffer_din !== 8'h42) begin errors++; $display("FAIL print_B: wen=%b addr=%0d din=%h want 1/1/42", buffer_wen, buffer_waddr, buffer_din); end
    checks++; if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin errors++; $display("FAIL print_B_cursor: row=%0d col=%0d want 0/2", cursor_row, cursor_col); end
    step();
    checks++; if (buffer_wen !== 1'b0) begin errors++; $display("FAIL print_idle_wen: got %b want 0", buffer_wen); end
  endtask

  task automatic test_right_edge();
    for (int i = 0; i < 77; i++) send_byte(8'h2E);
    checks++; if (cursor_col !== 7'd79) begin errors++; $display("FAIL edge_reach_col: got %0d want 79", cursor_col); end
    send_byte(8'h58);
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd79 || buffer_din !== 8'h58) begin errors++; $display("FAIL edge_X: wen=%b addr=%0d din=%h want 1/79/58", buffer_wen, buffer_waddr, buffer_din); end
    send_byte(8'h59);
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd79 || buffer_din !== 8'h59) begin errors++; $display("FAIL edge_Y: wen=%b addr=%0d din=%h want 1/79/59", buffer_wen, buffer_waddr, buffer_din); end
    checks++; if (cursor_col !== 7'd79) begin errors++; $display("FAIL edge_col_stuck: got %0d want 79", cursor_col); end
    send_byte(8'h0D);
    checks++; if (buffer_wen !== 1'b0 || cursor_col !== 7'd0) begin errors++; $display("FAIL cr: wen=%b col=%0d want 0/0", buffer_wen, cursor_col); end
    send_byte(8'h08);
    checks++; if (buffer_wen !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin errors++; $display("FAIL bs_col0: wen=%b row=%0d col=%0d want 0/0/0", buffer_wen, cursor_row, cursor_col); end
    send_byte(8'h5A);
    checks++; if (buffer_waddr !== 11'd0 || buffer_wen !== 1'b1) begin errors++; $display("FAIL after_cr_addr: wen=%b addr=%0d want 1/0", buffer_wen, buffer_waddr); end
    send_byte(8'h01);
    checks++; if (buffer_wen !== 1'b0 || cursor_col !== 7'd1) begin errors++; $display("FAIL ignored_byte: wen=%b col=%0d want 0/1", buffer_wen, cursor_col); end
    send_byte(8'h08);
    checks++; if (buffer_wen !== 1'b0 || cursor_col !== 7'd0) begin errors++; $display("FAIL bs: wen=%b col=%0d want 0/0", buffer_wen, cursor_col); end
    send_byte(8'h57);
    checks++; if (buffer_waddr !== 11'd0 || buffer_din !== 8'h57) begin errors++; $display("FAIL after_bs_addr: addr=%0d din=%h want 0/57", buffer_waddr, buffer_din); end
    send_byte(8'h0D);
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 23; i++) begin
      send_byte(8'h0A);
      checks++; if (buffer_wen !== 1'b0 || cursor_row !== 5'(i + 1)) begin errors++; $display("FAIL lf[%0d]: wen=%b row=%0d want 0/%0d", i, buffer_wen, cursor_row, i + 1); end
    end
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    checks++; if (buffer_waddr !== 11'd1844 || buffer_din !== 8'h65) begin errors++; $display("FAIL row23_addr: addr=%0d din=%h want 1844/65", buffer_waddr, buffer_din); end
    send_byte(8'h0A);
    // Hold a byte during the scroll: it must wait until ready returns.
    data_in = 8'h71; valid_in = 1'b1;
    checks++; if (ready_out !== 1'b0 || buffer_wen !== 1'b0) begin errors++; $display("FAIL scroll_start: ready=%b wen=%b want 0/0", ready_out, buffer_wen); end
    for (int k = 1; k <= 80; k++) begin
      step();
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(k - 1) || buffer_din !== 8'h20 || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL scroll_write[%0d]: wen=%b addr=%0d din=%h ready=%b want 1/%0d/20/0", k, buffer_wen, buffer_waddr, buffer_din, ready_out, k - 1);
      end
      checks++;
      if (buffer_first_char_wen !== (k == 80)) begin errors++; $display("FAIL scroll_fc_wen[%0d]: got %b want %b", k, buffer_first_char_wen, (k == 80)); end
    end
    checks++; if (buffer_first_char !== 11'd80) begin errors++; $display("FAIL scroll_fc: got %0d want 80", buffer_first_char); end
    checks++; if (cursor_row !== 5'd23 || cursor_col !== 7'd5) begin errors++; $display("FAIL scroll_cursor: row=%0d col=%0d want 23/5", cursor_row, cursor_col); end
    step();
    checks++; if (ready_out !== 1'b1 || buffer_wen !== 1'b0) begin errors++; $display("FAIL scroll_ready: ready=%b wen=%b want 1/0", ready_out, buffer_wen); end
    step();
    valid_in = 1'b0;
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd5 || buffer_din !== 8'h71) begin errors++; $display("FAIL after_scroll_char: wen=%b addr=%0d din=%h want 1/5/71", buffer_wen, buffer_waddr, buffer_din); end
    checks++; if (cursor_col !== 7'd6) begin errors++; $display("FAIL after_scroll_col: got %0d want 6", cursor_col); end
  endtask

  task automatic test_pointer_wrap();
    for (int s = 0; s < 22; s++) begin
      send_byte(8'h0A);
      wait_ready("wrap_scroll");
    end
    checks++; if (buffer_first_char !== 11'd1840) begin errors++; $display("FAIL wrap_fc_23: got %0d want 1840", buffer_first_char); end
    send_byte(8'h0D);
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
    checks++; if (buffer_waddr !== 11'd1762 || buffer_din !== 8'h32) begin errors++; $display("FAIL wrap_row23_addr: addr=%0d din=%h want 1762/32", buffer_waddr, buffer_din); end
    send_byte(8'h0A);
    for (int k = 1; k <= 80; k++) begin
      step();
      checks++;
      if (buffer_wen !== 1'b1 || buffer_waddr !== 11'(1839 + k) || buffer_first_char_wen !== (k == 80)) begin
        errors++;
        $display("FAIL wrap_write[%0d]: wen=%b addr=%0d fc_wen=%b want 1/%0d/%b", k, buffer_wen, buffer_waddr, buffer_first_char_wen, 1839 + k, (k == 80));
      end
    end
    checks++; if (buffer_first_char !== 11'd0) begin errors++; $display("FAIL wrap_fc: got %0d want 0", buffer_first_char); end
    wait_ready("wrap_last");
    send_byte(8'h72);
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd1843 || buffer_din !== 8'h72) begin errors++; $display("FAIL wrap_char: wen=%b addr=%0d din=%h want 1/1843/72", buffer_wen, buffer_waddr, buffer_din); end
  endtask

  task automatic test_mid_reset();
    send_byte(8'h0A);
    for (int k = 1; k <= 40; k++) step();
    checks++; if (buffer_waddr !== 11'd39 || buffer_wen !== 1'b1) begin errors++; $display("FAIL mid_pre: wen=%b addr=%0d want 1/39", buffer_wen, buffer_waddr); end
    clr = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b0 || buffer_wen !== 1'b0 || buffer_first_char_wen !== 1'b0 || buffer_waddr !== 11'd0 ||
        buffer_din !== 8'h00 || buffer_first_char !== 11'd0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b wen=%b fcw=%b addr=%0d din=%h fc=%0d row=%0d col=%0d want all 0",
               ready_out, buffer_wen, buffer_first_char_wen, buffer_waddr, buffer_din, buffer_first_char, cursor_row, cursor_col);
    end
    #1;
    clr = 1'b0;
    step();
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd0 || buffer_din !== 8'h20) begin errors++; $display("FAIL mid_init0: wen=%b addr=%0d din=%h want 1/0/20", buffer_wen, buffer_waddr, buffer_din); end
    step();
    checks++; if (buffer_wen !== 1'b1 || buffer_waddr !== 11'd1) begin errors++; $display("FAIL mid_init1: wen=%b addr=%0d want 1/1", buffer_wen, buffer_waddr); end
  endtask

  initial begin
    test_reset();
    test_init_clear();
    test_printable();
    test_right_edge();
    test_scroll();
    test_pointer_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
